// File: rtl/gardner_ted_param.sv
// Gardner timing error detector with internal I/Q delay lines.
// Each qualifying sample k produces
//   e = sat( ( I[k-H]*trunc(I[k-2H]-I[k]) + Q[k-H]*trunc(Q[k-2H]-Q[k]) ) >>> SHIFT )
// where H = HALF_SPS. A copy of e is also emitted once per symbol at a
// programmable symbol-counter phase for loop filters that run at symbol rate.
module gardner_ted_param #(
  parameter int WIDTH              = 16,
  parameter int HALF_SPS           = 16,
  parameter int DIFF_BITS          = 6,
  parameter int OUT_WIDTH          = 16,
  parameter int SHIFT              = 0,
  parameter int USE_SIMPLE_GARDNER = 0,
  parameter int SYM_PHASE          = 0
) (
  input  logic                        clk_32M768,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [WIDTH-1:0]     I,
  input  logic signed [WIDTH-1:0]     Q,
  input  logic                        phase_load,
  output logic                        primed,
  output logic signed [OUT_WIDTH-1:0] err_n,
  output logic                        err_valid,
  output logic signed [OUT_WIDTH-1:0] err_sym,
  output logic                        err_sym_valid
);

  localparam int DEPTH = 2 * HALF_SPS;
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = AW + 1;
  localparam int DW    = WIDTH + 1;
  localparam int TRUNC = DW - DIFF_BITS;
  localparam int PW    = WIDTH + DIFF_BITS;
  localparam int SW    = PW + 1;
  localparam int CW    = ((SW > OUT_WIDTH) ? SW : OUT_WIDTH) + 1;

  // Full-precision (older - newer) difference, floored down to DIFF_BITS.
  function automatic logic signed [DIFF_BITS-1:0] trunc_diff(
    input logic signed [WIDTH-1:0] older,
    input logic signed [WIDTH-1:0] newer
  );
    logic signed [DW-1:0] d;
    logic signed [DW-1:0] s;
    d = {older[WIDTH-1], older} - {newer[WIDTH-1], newer};
    s = d >>> TRUNC;
    return s[DIFF_BITS-1:0];
  endfunction

  // Midpoint weighting: true multiply, or sign(midpoint) in the simple variant.
  function automatic logic signed [PW-1:0] mid_product(
    input logic signed [WIDTH-1:0]     mid,
    input logic signed [DIFF_BITS-1:0] dt
  );
    logic signed [PW-1:0] dx;
    logic signed [PW-1:0] mx;
    dx = PW'(dt);
    mx = PW'(mid);
    if (USE_SIMPLE_GARDNER != 0) begin
      return mid[WIDTH-1] ? -dx : dx;
    end
    return mx * dx;
  endfunction

  // Arithmetic scale-down followed by clamping to the output range.
  function automatic logic signed [OUT_WIDTH-1:0] shift_sat(
    input logic signed [SW-1:0] s
  );
    logic signed [SW-1:0] sh;
    logic signed [CW-1:0] x;
    logic signed [CW-1:0] hi;
    logic signed [CW-1:0] lo;
    sh = s >>> SHIFT;
    x  = CW'(sh);
    hi = {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    lo = ~hi;
    if (x > hi) begin
      return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
    if (x < lo) begin
      return {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end
    return x[OUT_WIDTH-1:0];
  endfunction

  logic signed [WIDTH-1:0] mem_i [DEPTH];
  logic signed [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_mid;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_nxt;
  logic [AW-1:0] sym_cnt;
  logic [AW-1:0] sym_cur;
  logic          load_pend;
  logic          qual;
  logic          sym_hit;

  logic                        vld_p0, vld_p1, vld_p2;
  logic                        sym_p0, sym_p1, sym_p2;
  logic signed [DIFF_BITS-1:0] diff_i_p0, diff_q_p0;
  logic signed [WIDTH-1:0]     mid_i_p0, mid_q_p0;
  logic signed [PW-1:0]        prod_i_p1, prod_q_p1;
  logic signed [SW-1:0]        sum_p2;

  // Midpoint tap sits half a buffer away from the write pointer; the
  // oldest tap is the write address itself, read before it is overwritten.
  assign rd_mid   = wr_ptr + AW'(HALF_SPS);
  assign qual     = in_valid && (fill == FW'(DEPTH));
  assign fill_nxt = (in_valid && (fill != FW'(DEPTH))) ? fill + FW'(1) : fill;
  assign sym_cur  = (phase_load || load_pend) ? '0 : sym_cnt;
  assign sym_hit  = (sym_cur == AW'(SYM_PHASE));

  // Sample store: one write per valid sample, contents never cleared.
  always_ff @(posedge clk_32M768) begin
    if (in_valid) begin
      mem_i[wr_ptr] <= I;
      mem_q[wr_ptr] <= Q;
    end
  end

  // Write pointer, fill level, primed flag and symbol counter.
  always_ff @(posedge clk_32M768 or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      fill      <= '0;
      primed    <= 1'b0;
      sym_cnt   <= '0;
      load_pend <= 1'b0;
    end else begin
      fill   <= fill_nxt;
      primed <= (fill_nxt == FW'(DEPTH));
      if (in_valid) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (qual) begin
        sym_cnt   <= sym_cur + AW'(1);
        load_pend <= 1'b0;
      end else if (phase_load) begin
        load_pend <= 1'b1;
      end
    end
  end

  // Pipeline valids and symbol tags; cleared by reset, never stalled.
  always_ff @(posedge clk_32M768 or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      sym_p0 <= 1'b0;
      sym_p1 <= 1'b0;
      sym_p2 <= 1'b0;
    end else begin
      vld_p0 <= qual;
      sym_p0 <= qual && sym_hit;
      vld_p1 <= vld_p0;
      sym_p1 <= sym_p0;
      vld_p2 <= vld_p1;
      sym_p2 <= sym_p1;
    end
  end

  // Datapath stages p0..p2 run freely; valids decide what is meaningful.
  always_ff @(posedge clk_32M768) begin
    // p0: truncated late-early differences and midpoint samples
    diff_i_p0 <= trunc_diff(mem_i[wr_ptr], I);
    diff_q_p0 <= trunc_diff(mem_q[wr_ptr], Q);
    mid_i_p0  <= mem_i[rd_mid];
    mid_q_p0  <= mem_q[rd_mid];
    // p1: per-channel midpoint products
    prod_i_p1 <= mid_product(mid_i_p0, diff_i_p0);
    prod_q_p1 <= mid_product(mid_q_p0, diff_q_p0);
    // p2: I + Q with one growth bit
    sum_p2    <= SW'(prod_i_p1) + SW'(prod_q_p1);
  end

  // Output stage: shift+saturate, holding the last error between strobes.
  always_ff @(posedge clk_32M768 or posedge rst) begin
    if (rst) begin
      err_n         <= '0;
      err_valid     <= 1'b0;
      err_sym       <= '0;
      err_sym_valid <= 1'b0;
    end else begin
      err_valid     <= vld_p2;
      err_sym_valid <= sym_p2;
      if (vld_p2) begin
        err_n <= shift_sat(sum_p2);
      end
      if (sym_p2) begin
        err_sym <= shift_sat(sum_p2);
      end
    end
  end

endmodule

// File: tb/tb_gardner_ted_param.sv
// Directed bench for gardner_ted_param: a full-multiply and a sign-only
// instance are driven with identical I/Q streams and checked every cycle.
module tb_gardner_ted_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               in_valid;
  logic               phase_load;
  logic signed [15:0] i_s;
  logic signed [15:0] q_s;

  logic               primed, err_valid, err_sym_valid;
  logic signed [15:0] err_n, err_sym;
  logic               primed2, err_valid2, err_sym_valid2;
  logic signed [15:0] err_n2, err_sym2;

  gardner_ted_param u_full (
    .clk_32M768(clk), .rst(rst), .in_valid(in_valid), .I(i_s), .Q(q_s),
    .phase_load(phase_load), .primed(primed), .err_n(err_n),
    .err_valid(err_valid), .err_sym(err_sym), .err_sym_valid(err_sym_valid)
  );

  gardner_ted_param #(.USE_SIMPLE_GARDNER(1)) u_simple (
    .clk_32M768(clk), .rst(rst), .in_valid(in_valid), .I(i_s), .Q(q_s),
    .phase_load(phase_load), .primed(primed2), .err_n(err_n2),
    .err_valid(err_valid2), .err_sym(err_sym2), .err_sym_valid(err_sym_valid2)
  );

  int    ntests = 0;
  int    nfail  = 0;
  string phase  = "init";

  int   nvalid;
  logic ev_q [4];
  int   ef_q [4];
  int   ex_q [4];
  logic sv_q [4];
  int   hold_e, hold_s, hold_e2;

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s/%s: got %0b expected %0b", phase, tag, got, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic signed [15:0] got, input int exp);
    logic signed [15:0] e16;
    e16 = exp[15:0];
    ntests++;
    assert (got === e16) else begin
      nfail++;
      $error("FAIL %s/%s: got %0d expected %0d", phase, tag, got, e16);
    end
  endtask

  task automatic clear_model();
    nvalid  = 0;
    hold_e  = 0;
    hold_s  = 0;
    hold_e2 = 0;
    for (int j = 0; j < 4; j++) begin
      ev_q[j] = 1'b0;
      ef_q[j] = 0;
      ex_q[j] = 0;
      sv_q[j] = 1'b0;
    end
  endtask

  task automatic chk_zero_outputs();
    chk_bit("rst_primed", primed, 1'b0);
    chk_bit("rst_err_valid", err_valid, 1'b0);
    chk_val("rst_err_n", err_n, 0);
    chk_bit("rst_err_sym_valid", err_sym_valid, 1'b0);
    chk_val("rst_err_sym", err_sym, 0);
    chk_bit("rst_err_valid2", err_valid2, 1'b0);
    chk_val("rst_err_n2", err_n2, 0);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    phase_load = 1'b0;
    i_s        = '0;
    q_s        = '0;
    @(posedge clk); #1;
    chk_zero_outputs();
    rst = 1'b0;
    clear_model();
  endtask

  // One clock: drive a sample, then check outputs against the sample
  // issued four calls earlier. ef/ex are the full/simple expected errors,
  // sv says whether this sample should also appear on err_sym.
  task automatic cyc(input logic v, input int iv, input int qv, input logic pl,
                     input int ef, input int ex, input logic sv);
    logic ev;
    ev         = v && (nvalid >= 32);
    in_valid   = v;
    i_s        = iv[15:0];
    q_s        = qv[15:0];
    phase_load = pl;
    if (v && nvalid < 32) nvalid++;
    @(posedge clk); #1;
    for (int j = 3; j > 0; j--) begin
      ev_q[j] = ev_q[j-1];
      ef_q[j] = ef_q[j-1];
      ex_q[j] = ex_q[j-1];
      sv_q[j] = sv_q[j-1];
    end
    ev_q[0] = ev;
    ef_q[0] = ef;
    ex_q[0] = ex;
    sv_q[0] = ev && sv;
    if (ev_q[3]) begin
      hold_e  = ef_q[3];
      hold_e2 = ex_q[3];
      if (sv_q[3]) hold_s = ef_q[3];
    end
    chk_bit("primed", primed, nvalid >= 32);
    chk_bit("primed2", primed2, nvalid >= 32);
    chk_bit("err_valid", err_valid, ev_q[3]);
    chk_val("err_n", err_n, hold_e);
    chk_bit("err_sym_valid", err_sym_valid, sv_q[3]);
    chk_val("err_sym", err_sym, hold_s);
    chk_bit("err_valid2", err_valid2, ev_q[3]);
    chk_val("err_n2", err_n2, hold_e2);
  endtask

  task automatic flush();
    for (int j = 0; j < 5; j++) cyc(1'b0, 12345, -321, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    phase_load = 1'b0;
    i_s        = '0;
    q_s        = '0;
    clear_model();
    #3;
    chk_zero_outputs();

    // Constant input: primed after sample 31, zero error from sample 32 on.
    phase = "const";
    do_reset();
    for (int k = 0; k < 40; k++) cyc(1'b1, 1000, 0, 1'b0, 0, 0, (k % 32) == 0);
    flush();

    // Ramp I=64k: diff_t=-1, so e = -I[k-16] = -(k-16)*64; simple mode gives -1.
    phase = "ramp";
    do_reset();
    for (int k = 0; k <= 100; k++)
      cyc(1'b1, 64 * k, 0, 1'b0, -(k - 16) * 64, -1, (k % 32) == 0);
    flush();

    // Same ramp with in_valid toggling; idle cycles carry junk that must be ignored.
    phase = "toggle";
    do_reset();
    for (int k = 0; k <= 60; k++) begin
      cyc(1'b1, 64 * k, 0, 1'b0, -(k - 16) * 64, -1, (k % 32) == 0);
      cyc(1'b0, 7777, -5, 1'b0, 0, 0, 1'b0);
    end
    flush();

    // Reset in the middle of a stream, then refill from scratch.
    phase = "midrst";
    do_reset();
    for (int k = 0; k < 50; k++)
      cyc(1'b1, 64 * k, 0, 1'b0, -(k - 16) * 64, -1, (k % 32) == 0);
    in_valid = 1'b1;
    i_s      = 16'sd3200;
    #1;
    rst = 1'b1;
    #1;
    chk_zero_outputs();
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    clear_model();
    for (int k = 0; k <= 40; k++)
      cyc(1'b1, 64 * k, 0, 1'b0, -(k - 16) * 64, -1, (k % 32) == 0);
    flush();

    // Negative saturation: mid=32767, oldest=-32768, newest=32767 on I and Q.
    // diff_t=-32, sum=-2097088 -> -32768; simple: 2*(-32) = -64.
    phase = "satneg";
    do_reset();
    for (int k = 0; k < 48; k++) begin
      int v;
      v = (k < 16) ? -32768 : 32767;
      cyc(1'b1, v, v, 1'b0, -32768, -64, (k % 32) == 0);
    end
    flush();

    // Positive saturation: mid=-32768 gives +2097152 -> 32767; simple: +64.
    phase = "satpos";
    do_reset();
    for (int k = 0; k < 36; k++) begin
      int v;
      v = (k < 32) ? -32768 : 32767;
      cyc(1'b1, v, v, 1'b0, 32767, 64, (k % 32) == 0);
    end
    flush();

    // phase_load with a sample at k=40, then a pending load on an idle cycle.
    phase = "phload";
    do_reset();
    for (int k = 0; k <= 80; k++)
      cyc(1'b1, 64 * k, 0, k == 40, -(k - 16) * 64, -1, (k == 32) || (k == 40) || (k == 72));
    cyc(1'b0, 999, 0, 1'b1, 0, 0, 1'b0);
    for (int k = 81; k <= 84; k++)
      cyc(1'b1, 64 * k, 0, 1'b0, -(k - 16) * 64, -1, k == 81);
    flush();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
